// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and state encoding for the display arbiter
`timescale 1ns/100ps
package display_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int DIGIT_W     = 4;
  localparam int DISP_W      = NUM_DIGITS * DIGIT_W;
  localparam int SCAN_PERIOD = 4095;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_GRANT = GRANT,
    ST_GAP   = GAP
  } arb_state_t;

  // Index width that never collapses to zero bits for single-entry sets.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// rtl/display_arbiter_rr_pick.sv - combinational round-robin picker starting after 'last'
`timescale 1ns/100ps
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            found,
  output logic [IW-1:0]   idx
);

  function automatic logic [IW-1:0] slot(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % NREQ);
  endfunction

  // Scan from the farthest slot back to the nearest so the nearest requester wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[slot(last, k)]) begin
        found = 1'b1;
        idx   = slot(last, k);
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin owner of the multiplexed seven-segment value input
`timescale 1ns/100ps
module display_arbiter
  import display_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int MIN_HOLD   = NUM_DIGITS * SCAN_PERIOD,
  parameter  int MAX_HOLD   = 65520,
  parameter  int GAP_CYCLES = 4,
  localparam int OW         = clog2_min1(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [DISP_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [OW-1:0]          owner,
  output logic [DISP_W-1:0]      disp_val,
  output logic                   blank,
  output logic                   busy
);

  localparam int HOLD_W = clog2_min1(MAX_HOLD);
  localparam int GAP_W  = clog2_min1(GAP_CYCLES);

  arb_state_t        state_q, state_d;
  logic [NREQ-1:0]   gnt_d;
  logic [OW-1:0]     owner_d, last_q, last_d;
  logic [DISP_W-1:0] disp_d;
  logic              blank_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              pick_found;
  logic [OW-1:0]     pick_idx;
  logic              load_grant;
  logic              own_req, others_req, min_done, max_done;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own_req    = req[owner];
  assign others_req = |(req & ~gnt);
  assign min_done   = (hold_q >= HOLD_W'(MIN_HOLD - 1));
  assign max_done   = (hold_q >= HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt;
    owner_d    = owner;
    disp_d     = disp_val;
    blank_d    = blank;
    hold_d     = hold_q;
    gap_d      = gap_q;
    last_d     = last_q;
    load_grant = 1'b0;

    case (state_q)
      ST_IDLE: begin
        load_grant = pick_found;
      end
      ST_GRANT: begin
        if ((min_done && !own_req) || (max_done && others_req)) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          blank_d = 1'b1;
          last_d  = owner;
          gap_d   = '0;
        end else begin
          if (!max_done) hold_d = hold_q + 1'b1;
          if (own_req) disp_d = req_data[int'(owner)*DISP_W +: DISP_W];
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          load_grant = pick_found;
          if (!pick_found) state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_grant) begin
      state_d           = ST_GRANT;
      gnt_d             = '0;
      gnt_d[pick_idx]   = 1'b1;
      owner_d           = pick_idx;
      disp_d            = req_data[int'(pick_idx)*DISP_W +: DISP_W];
      hold_d            = '0;
      blank_d           = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt      <= '0;
      owner    <= '0;
      disp_val <= '0;
      blank    <= 1'b1;
      hold_q   <= '0;
      gap_q    <= '0;
      last_q   <= OW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      owner    <= owner_d;
      disp_val <= disp_d;
      blank    <= blank_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      last_q   <= last_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - vector, directed and randomized checks of display_arbiter
`timescale 1ns/100ps
module tb_display_arbiter;

  localparam int NREQ = 4;
  localparam int MINH = 8;
  localparam int MAXH = 20;
  localparam int GAPC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [15:0] disp_val;
  logic        blank, busy;

  int checks = 0;
  int passed = 0;

  display_arbiter #(.NREQ(NREQ), .MIN_HOLD(MINH), .MAX_HOLD(MAXH), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .owner(owner), .disp_val(disp_val), .blank(blank), .busy(busy)
  );

  always #1 clk = ~clk;

  // Reference: 0 idle, 1 granted, 2 blank gap; m_since = cycles already owned.
  int          m_mode, m_owner, m_last, m_since, m_gap;
  logic [15:0] m_dv;

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_last = NREQ - 1; m_since = 0; m_gap = 0; m_dv = '0;
  endtask

  function automatic int rr(input logic [3:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic model_grant(input int p, input logic [63:0] d);
    m_mode = 1; m_owner = p; m_dv = d[16*p +: 16]; m_since = 1;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [63:0] d);
    int p;
    p = rr(r, m_last);
    if (m_mode == 0) begin
      if (p >= 0) model_grant(p, d);
    end else if (m_mode == 1) begin
      if ((m_since >= MINH && !r[m_owner]) ||
          (m_since >= MAXH && (r & ~(4'b1 << m_owner)) != 4'b0)) begin
        m_mode = 2; m_gap = 1; m_last = m_owner;
      end else begin
        m_since++;
        if (r[m_owner]) m_dv = d[16*m_owner +: 16];
      end
    end else begin
      if (m_gap == GAPC) begin
        if (p >= 0) model_grant(p, d);
        else m_mode = 0;
      end else begin
        m_gap++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [23:0] model_out();
    logic [3:0] g;
    g = (m_mode == 1) ? (4'b1 << m_owner) : 4'b0;
    return {g, 2'(m_owner), m_dv, (m_mode != 1), (m_mode != 0)};
  endfunction

  // Drive at a falling edge, let one rising edge act, observe at the next falling edge.
  task automatic tick(input logic [3:0] r, input logic [63:0] d);
    req = r; req_data = d;
    @(posedge clk);
    if (rst) model_reset(); else model_step(r, d);
    @(negedge clk);
    chk("model", 64'({gnt, owner, disp_val, blank, busy}), 64'(model_out()));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    int          sel;
    logic [15:0] d;
    logic [3:0]  gnt;
    logic [1:0]  own;
    logic [15:0] dv;
    logic        blank;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, input int sel, input logic [15:0] d,
                     input logic [3:0] g, input logic [1:0] o, input logic [15:0] dv,
                     input logic bl, input logic bz);
    vec_t v;
    v.req = r; v.sel = sel; v.d = d; v.gnt = g; v.own = o; v.dv = dv; v.blank = bl; v.busy = bz;
    vecs.push_back(v);
  endtask

  logic [63:0] dd;
  logic [63:0] fixed_d;
  logic        held;
  int          n, b;

  initial begin
    fixed_d = 64'h3333_2222_1111_0000;
    @(negedge clk);
    do_reset();

    // Idle after reset
    chk("rst_out", 64'({gnt, owner, disp_val, blank, busy}), 64'({4'b0, 2'd0, 16'h0000, 1'b1, 1'b0}));
    tick(4'b0, fixed_d);
    tick(4'b0, fixed_d);
    chk("idle_out", 64'({gnt, blank, busy}), 64'({4'b0, 1'b1, 1'b0}));

    // Single grant, data follow, min hold, gap, then a short pulse on requester 1
    add(4'b0100, 2, 16'h1234, 4'b0100, 2, 16'h1234, 0, 1);
    add(4'b0100, 2, 16'h9999, 4'b0100, 2, 16'h9999, 0, 1);
    for (int i = 2; i < 8; i++) add(4'b0000, 2, 16'h7777, 4'b0100, 2, 16'h9999, 0, 1);
    for (int i = 8; i < 10; i++) add(4'b0000, 2, 16'h7777, 4'b0000, 2, 16'h9999, 1, 1);
    add(4'b0000, 1, 16'h0000, 4'b0000, 2, 16'h9999, 1, 0);
    for (int i = 11; i < 14; i++) add(4'b0010, 1, 16'h5555, 4'b0010, 1, 16'h5555, 0, 1);
    for (int i = 14; i < 19; i++) add(4'b0000, 1, 16'h0bad, 4'b0010, 1, 16'h5555, 0, 1);
    for (int i = 19; i < 21; i++) add(4'b0000, 1, 16'h0bad, 4'b0000, 1, 16'h5555, 1, 1);
    add(4'b0000, 1, 16'h0bad, 4'b0000, 1, 16'h5555, 1, 0);
    foreach (vecs[i]) begin
      for (int s = 0; s < 4; s++) dd[16*s +: 16] = (s == vecs[i].sel) ? vecs[i].d : 16'hbad0;
      tick(vecs[i].req, dd);
      chk($sformatf("vec%0d", i), 64'({gnt, owner, disp_val, blank, busy}),
          64'({vecs[i].gnt, vecs[i].own, vecs[i].dv, vecs[i].blank, vecs[i].busy}));
    end

    // Round robin with everyone requesting
    do_reset();
    for (int g = 0; g < 5; g++) begin
      b = 0;
      while (gnt == 4'b0 && b < 10) begin tick(4'hf, fixed_d); b++; end
      chk($sformatf("rr_gap%0d", g), 64'(b), (g == 0) ? 64'd1 : 64'(GAPC));
      chk($sformatf("rr_owner%0d", g), 64'({gnt, owner}), 64'({4'b1 << (g % 4), 2'(g % 4)}));
      n = 0;
      while (gnt != 4'b0 && n < 40) begin tick(4'hf, fixed_d); n++; end
      chk($sformatf("rr_len%0d", g), 64'(n), 64'(MAXH));
    end

    // Sole requester saturates, a newcomer preempts it
    do_reset();
    held = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick(4'b1000, fixed_d);
      if (gnt != 4'b1000 || blank) held = 1'b0;
    end
    chk("sole_hold", 64'(held), 64'd1);
    tick(4'b1001, fixed_d);
    chk("preempt_drop", 64'({gnt, blank}), 64'({4'b0, 1'b1}));
    tick(4'b1001, fixed_d);
    chk("preempt_gap", 64'({gnt, blank}), 64'({4'b0, 1'b1}));
    tick(4'b1001, fixed_d);
    chk("preempt_new", 64'({gnt, owner, disp_val}), 64'({4'b0001, 2'd0, 16'h0000}));

    // Asynchronous reset in the middle of a grant
    @(negedge clk);
    rst = 1'b1;
    #0.2;
    chk("async_rst", 64'({gnt, owner, disp_val, blank, busy}), 64'({4'b0, 2'd0, 16'h0000, 1'b1, 1'b0}));
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Wrap: last owner 3 re-granted when alone, then 1 beats 2
    tick(4'b1000, fixed_d);
    n = 0;
    while (gnt != 4'b0 && n < 30) begin tick(4'b0000, fixed_d); n++; end
    chk("wrap_minlen", 64'(n), 64'(MINH));
    tick(4'b1000, fixed_d);
    tick(4'b1000, fixed_d);
    chk("wrap_regrant", 64'({gnt, owner}), 64'({4'b1000, 2'd3}));
    n = 0;
    while (gnt != 4'b0 && n < 30) begin tick(4'b0000, fixed_d); n++; end
    tick(4'b0110, fixed_d);
    tick(4'b0110, fixed_d);
    chk("wrap_pick1", 64'({gnt, owner, disp_val}), 64'({4'b0010, 2'd1, 16'h1111}));

    // Randomized traffic against the reference
    do_reset();
    req = '0;
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] r;
      r = req;
      for (int s = 0; s < 4; s++) if ($urandom_range(15) == 0) r[s] = ~r[s];
      tick(r, {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
